muldiv_issue: RTL

- Issue/retire controller directly upstream and downstream of the M-extension multiplier/divider in the EX stage.
- Accepts decoded M-extension ops (funct3 + W flag) from the issue stage via a valid/ready handshake.
- Prepares operands and holds mul_op/operands stable for the whole multiplier busy window.
- Post-processes W-variant results and presents them to writeback via valid/ready; handles pipeline flush of an in-flight op.

---
 rtl/riscv_pkg.sv | 41 ++++
 rtl/muldiv_issue.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/riscv_pkg.sv
// Shared M-extension types and decode helpers for the EX-stage multiplier/divider path.
package riscv_pkg;

    typedef enum logic [3:0] {
        M_NONE,
        M_MUL,
        M_MULH,
        M_MULHSU,
        M_MULHU,
        M_DIV,
        M_DIVU,
        M_REM,
        M_REMU
    } mul_op_t;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        BUSY,
        RESP,
        DRAIN
    } state_t;

    function automatic mul_op_t funct3_to_op(input logic [2:0] funct3);
        case (funct3)
            3'b000:  return M_MUL;
            3'b001:  return M_MULH;
            3'b010:  return M_MULHSU;
            3'b011:  return M_MULHU;
            3'b100:  return M_DIV;
            3'b101:  return M_DIVU;
            3'b110:  return M_REM;
            default: return M_REMU;
        endcase
    endfunction

    function automatic logic is_div(input mul_op_t op);
        return op >= M_DIV;
    endfunction

endpackage

// File: rtl/muldiv_issue.sv
// Issue/retire controller around the M-extension multiplier/divider: operand prep,
// busy-window hold, W-result sign extension, writeback handshake and flush handling.
module muldiv_issue
    import riscv_pkg::*;
#(
    parameter int unsigned TIMEOUT = 48
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        valid_i,
    output logic        ready_o,
    input  logic [2:0]  funct3_i,
    input  logic        is_word_i,
    input  logic [63:0] rs1_i,
    input  logic [63:0] rs2_i,
    input  logic [4:0]  rd_i,
    input  logic        flush_i,
    output mul_op_t     mul_op_o,
    output logic [63:0] op_a_o,
    output logic [63:0] op_b_o,
    input  logic        stall_mul_i,
    input  logic [63:0] mul_result_i,
    output logic        wb_valid_o,
    input  logic        wb_ready_i,
    output logic [4:0]  wb_rd_o,
    output logic [63:0] wb_data_o,
    output logic        timeout_o
);

    localparam int unsigned TW = $clog2(TIMEOUT + 1);

    state_t      state_q, state_d;
    mul_op_t     op_q, new_op;
    logic [4:0]  rd_q;
    logic        word_q;
    logic [63:0] op_a_q, op_b_q, wb_data_q;
    logic [63:0] prep_a, prep_b, result;
    logic [TW-1:0] timer_q;
    logic        timeout_q;
    logic        accept, illegal, in_wait, expired, capture;

    always_comb begin
        new_op  = funct3_to_op(funct3_i);
        illegal = is_word_i && !is_div(new_op) && (new_op != M_MUL);
        prep_a  = rs1_i;
        prep_b  = rs2_i;
        if (is_word_i && is_div(new_op)) begin
            if (new_op == M_DIV || new_op == M_REM) begin
                prep_a = {{32{rs1_i[31]}}, rs1_i[31:0]};
                prep_b = {{32{rs2_i[31]}}, rs2_i[31:0]};
            end else begin
                prep_a = {32'b0, rs1_i[31:0]};
                prep_b = {32'b0, rs2_i[31:0]};
            end
        end
    end

    assign result  = word_q ? {{32{mul_result_i[31]}}, mul_result_i[31:0]} : mul_result_i;
    assign ready_o = rst_n && (state_q == IDLE);
    assign accept  = ready_o && valid_i && !flush_i;
    assign in_wait = (state_q == BUSY) || (state_q == DRAIN);
    assign expired = in_wait && stall_mul_i && (timer_q == TW'(TIMEOUT - 1));

    always_comb begin
        state_d    = state_q;
        capture    = 1'b0;
        mul_op_o   = M_NONE;
        wb_valid_o = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) state_d = illegal ? RESP : ISSUE;
            end
            ISSUE: begin
                mul_op_o = op_q;
                state_d  = flush_i ? DRAIN : BUSY;
            end
            BUSY: begin
                mul_op_o = op_q;
                // A flush landing on the DONE cycle retires straight to IDLE; DRAIN
                // would keep the op asserted and restart the multiplier.
                if (!stall_mul_i) begin
                    if (flush_i) begin
                        state_d = IDLE;
                    end else begin
                        state_d = RESP;
                        capture = 1'b1;
                    end
                end else if (expired) begin
                    state_d = IDLE;
                end else if (flush_i) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                mul_op_o = op_q;
                if (!stall_mul_i || expired) state_d = IDLE;
            end
            RESP: begin
                wb_valid_o = 1'b1;
                if (flush_i || wb_ready_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            op_q      <= M_NONE;
            rd_q      <= '0;
            word_q    <= 1'b0;
            op_a_q    <= '0;
            op_b_q    <= '0;
            wb_data_q <= '0;
            timer_q   <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                op_q      <= new_op;
                rd_q      <= rd_i;
                word_q    <= is_word_i;
                op_a_q    <= prep_a;
                op_b_q    <= prep_b;
                wb_data_q <= '0;
            end
            if (capture) wb_data_q <= result;
            if (in_wait && (state_d == BUSY || state_d == DRAIN)) begin
                timer_q <= timer_q + 1'b1;
            end else begin
                timer_q <= '0;
            end
            if (expired) timeout_q <= 1'b1;
        end
    end

    assign op_a_o    = op_a_q;
    assign op_b_o    = op_b_q;
    assign wb_rd_o   = rd_q;
    assign wb_data_o = wb_data_q;
    assign timeout_o = timeout_q;

endmodule
